shake_absorb_padder: RTL and testbench
======================================

Name: shake_absorb_padder

Overview:
- Sequential, parametrised padder for the Keccak sponge front end. It takes a byte-granular message stream in W-bit words and packs it into RATE-bit blocks.
- On the final block it applies the domain-suffix + pad10*1 padding. Messages that end exactly on a block boundary get an extra padding-only block.
- Sits between the message source and the permutation/absorb stage, which consumes whole RATE blocks.
- Generalises the fixed-1088-bit SHAKE256 padding to any rate, word width and domain suffix, and adds a ready/valid handshake on both sides.

Parameters:
- RATE, 1088, block size in bits (1088 = SHAKE256, 1344 = SHAKE128, 1088/832/576 = SHA3-256/384/512). Must be a multiple of W.
- W, 64, input word width in bits. Multiple of 8.
- DS, 8'h1F, domain-suffix byte, pre-combined with the first pad bit (8'h1F = SHAKE, 8'h06 = SHA3).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  W  message word; first byte in bits [W-1:W-8]
- in_valid  in  1  in_data/in_last/in_bytes valid
- in_last  in  1  final word of the message
- in_bytes  in  $clog2(W/8)+1  valid bytes in the last word, 0..W/8, counted from the MSB end; ignored when in_last=0
- in_ready  out  1  padder accepts a word this cycle
- out_data  out  RATE  padded block; message byte 0 in bits [RATE-1:RATE-8]
- out_valid  out  1  out_data valid
- out_last  out  1  block is the final (padded) block of the message
- out_ready  in  1  downstream accepts the block

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_last=0, out_data=0, in_ready=0 during reset.
  - Word counter is cleared and the state is FILL.
  - in_ready=1 from the first cycle after rst deasserts.
  - A reset mid-message or mid-output discards everything. No partial block is ever emitted.
- States: FILL, EMIT, EMIT_PAD.
- FILL:
  - in_ready=1, out_valid=0.
  - Word counter widx runs 0..RATE/W-1.
  - An accepted word (in_valid & in_ready) is written to slot widx, at bits [RATE-1-widx*W -: W].
  - The buffer is all-zero at the start of every block, so unwritten slots stay 0.
- Non-last word:
  - If widx==RATE/W-1: go to EMIT with out_last=0 and widx=0.
  - Otherwise widx++.
- Last word with in_bytes=k:
  - Bytes beyond k in that word are forced to 0.
  - Pad position p = widx*W/8 + k, in bytes from the block start.
  - If p < RATE/8: byte p ^= DS, byte RATE/8-1 ^= 8'h80 (bits [7:0]). Go to EMIT with out_last=1.
  - If p == RATE/8-1, that byte equals DS^8'h80 (8'h9F for SHAKE).
  - If p == RATE/8 (block exactly full): go to EMIT with out_last=0 and set pad_pending.
  - k=0 is legal and means the message ended on the previous word. Empty message = single last word with k=0 at widx=0.
- EMIT:
  - out_valid=1, in_ready=0. out_data and out_last are held stable until out_valid & out_ready.
  - On handshake with pad_pending: load the pad-only block (byte 0 = DS, byte RATE/8-1 = 8'h80, rest 0), clear pad_pending, go to EMIT_PAD.
  - On handshake otherwise: clear the buffer, go to FILL.
- EMIT_PAD:
  - Same as EMIT with out_last=1. On handshake, clear the buffer and go to FILL.
- Latency:
  - out_valid rises the cycle after the block-completing word is accepted.
  - in_ready rises the cycle after the output handshake.
- Throughput: one word per cycle in FILL. There is no overlap of fill and emit, so each block costs RATE/W + 1 cycles minimum.
- out_data is registered, with no combinational path from in_* to out_*.
- in_valid while in_ready=0 has no effect. The source holds the word.
- in_bytes > W/8 is illegal. Its result is unspecified, and the bench flags it with an assertion.

Test Plan:
- RATE=1088, W=64, DS=8'h1F for all scenarios unless stated.
- Empty message: one word, in_last=1, in_bytes=0 -> single block: bits [1087:1080]=8'h1F, bits [7:0]=8'h80, rest 0; out_last=1.
- 3-byte message 0xAABBCC: in_data=64'hAABBCC_FFFFFFFFFF, in_bytes=3 -> block starts 0xAABBCC1F, then zeros, last byte 0x80 (garbage bytes masked); out_last=1.
- 135-byte message: 16 full words + last word with in_bytes=7 -> one block with byte 135 = 8'h9F; out_last=1; out_valid one cycle after the 17th accept.
- 136-byte message: 17 full words, last in_bytes=8 -> block 1 = raw data, out_last=0; then block 2 = 8'h1F…8'h80, out_last=1; exactly two output handshakes.
- Backpressure: 200-byte message with out_ready low for 5 cycles on each block -> out_data/out_valid/out_last held stable, in_ready=0 throughout EMIT; block 2 carries byte 64 = 8'h1F and byte 135 = 8'h80.
- Reset mid-fill after 5 words, then the empty message -> no block emitted before the reset; the next block exactly matches scenario 1. Repeat with DS=8'h06, RATE=576 -> byte 0 = 8'h06, byte 71 = 8'h80.

Source files
------------

// File: rtl/shake_absorb_padder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : shake_absorb_padder                                           |
// | Purpose  : Packs a byte-granular W-bit message stream into RATE-bit      |
// |            Keccak sponge blocks. It applies domain-suffix + pad10*1      |
// |            padding on the final block, and emits an extra padding-only   |
// |            block when the message ends exactly on a block boundary.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module shake_absorb_padder #(
  parameter int         RATE = 1088,
  parameter int         W    = 64,
  parameter logic [7:0] DS   = 8'h1F
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [$clog2(W/8):0]   in_bytes,
  output logic                   in_ready,
  output logic [RATE-1:0]        out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready
);

  localparam int c_WORDS = RATE / W;
  localparam int c_WB    = W / 8;
  localparam int c_BYTES = RATE / 8;
  localparam int c_IW    = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
  localparam int c_BW    = $clog2(W / 8) + 1;
  localparam int c_PW    = $clog2(c_BYTES + 1) + 1;
  localparam int c_SW    = $clog2(RATE + 1) + 1;

  localparam logic [1:0] c_FILL     = 2'd0;
  localparam logic [1:0] c_EMIT     = 2'd1;
  localparam logic [1:0] c_EMIT_PAD = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [RATE-1:0] r_buf;
  logic [c_IW-1:0] r_widx;
  logic            r_pad_pending;
  logic            r_last;

  logic            w_accept;
  logic            w_out_hs;
  logic            w_last_slot;
  logic [W-1:0]    w_masked;
  logic [c_PW-1:0] w_pos;
  logic            w_full;
  logic [c_SW-1:0] w_word_shift;
  logic [c_SW-1:0] w_pad_shift;
  logic [RATE-1:0] w_word_blk;
  logic [RATE-1:0] w_ds_blk;
  logic [RATE-1:0] w_fill_buf;
  logic [RATE-1:0] w_pad_only;

  assign w_accept    = in_valid & in_ready;
  assign w_out_hs    = out_valid & out_ready;
  assign w_last_slot = (r_widx == c_IW'(c_WORDS - 1));

  // Pad position in bytes from the block start; equals RATE/8 when the
  // final word fills the block completely.
  assign w_pos        = c_PW'(r_widx) * c_PW'(c_WB) + c_PW'(in_bytes);
  assign w_full       = (w_pos == c_PW'(c_BYTES));
  assign w_word_shift = c_SW'(r_widx) * c_SW'(W);
  assign w_pad_shift  = c_SW'(w_pos) * c_SW'(8);

  assign out_data = r_buf;

  // Zero the bytes past in_bytes on the final word (byte 0 sits at the MSB end).
  always_comb begin
    w_masked = in_data;
    for (int b = 0; b < c_WB; b++) begin
      if (in_last && (c_BW'(b) >= in_bytes)) begin
        w_masked[W-1-8*b -: 8] = 8'h00;
      end
    end
  end

  // Next buffer contents for an accepted word, with padding folded in
  // when this word closes a message that does not fill the block.
  always_comb begin
    w_word_blk              = '0;
    w_word_blk[RATE-1 -: W] = w_masked;
    w_ds_blk                = '0;
    w_ds_blk[RATE-1 -: 8]   = DS;
    w_fill_buf              = r_buf | (w_word_blk >> w_word_shift);
    if (in_last && !w_full) begin
      w_fill_buf       = w_fill_buf ^ (w_ds_blk >> w_pad_shift);
      w_fill_buf[7:0]  = w_fill_buf[7:0] ^ 8'h80;
    end
  end

  // Padding-only block used after a message that ended on a block boundary.
  always_comb begin
    w_pad_only              = '0;
    w_pad_only[RATE-1 -: 8] = DS;
    w_pad_only[7:0]         = w_pad_only[7:0] ^ 8'h80;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_FILL: begin
        if (w_accept && (in_last || w_last_slot)) begin
          w_state_nxt = c_EMIT;
        end
      end
      c_EMIT: begin
        if (w_out_hs) begin
          w_state_nxt = r_pad_pending ? c_EMIT_PAD : c_FILL;
        end
      end
      c_EMIT_PAD: begin
        if (w_out_hs) begin
          w_state_nxt = c_FILL;
        end
      end
      default: w_state_nxt = c_FILL;
    endcase
  end

  // Handshake outputs; everything is held low while reset is asserted.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (!rst) begin
      case (r_state)
        c_FILL:     in_ready = 1'b1;
        c_EMIT: begin
          out_valid = 1'b1;
          out_last  = r_last;
        end
        c_EMIT_PAD: begin
          out_valid = 1'b1;
          out_last  = 1'b1;
        end
        default: begin
          in_ready  = 1'b0;
          out_valid = 1'b0;
        end
      endcase
    end
  end

  // Block buffer, word counter and final-block bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf         <= '0;
      r_widx        <= '0;
      r_pad_pending <= 1'b0;
      r_last        <= 1'b0;
    end else begin
      case (r_state)
        c_FILL: begin
          if (w_accept) begin
            r_buf <= w_fill_buf;
            if (in_last) begin
              r_widx        <= '0;
              r_last        <= !w_full;
              r_pad_pending <= w_full;
            end else if (w_last_slot) begin
              r_widx        <= '0;
              r_last        <= 1'b0;
              r_pad_pending <= 1'b0;
            end else begin
              r_widx <= r_widx + c_IW'(1);
            end
          end
        end
        c_EMIT: begin
          if (w_out_hs) begin
            r_buf         <= r_pad_pending ? w_pad_only : '0;
            r_pad_pending <= 1'b0;
          end
        end
        c_EMIT_PAD: begin
          if (w_out_hs) begin
            r_buf <= '0;
          end
        end
        default: r_buf <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shake_absorb_padder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_shake_absorb_padder                                        |
// | Purpose  : Directed, table-driven bench for shake_absorb_padder          |
// |            (RATE=1088/DS=1F main instance, RATE=576/DS=06 second one).   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_shake_absorb_padder;

  logic          clk = 1'b0;
  logic          rst, rst2;
  logic [63:0]   in_data, d2_in_data;
  logic          in_valid, in_last, d2_in_valid, d2_in_last;
  logic [3:0]    in_bytes, d2_in_bytes;
  logic          in_ready, d2_in_ready;
  logic [1087:0] out_data;
  logic [575:0]  d2_out_data;
  logic          out_valid, out_last, out_ready;
  logic          d2_out_valid, d2_out_last, d2_out_ready;

  int checks = 0;
  int errors = 0;
  int hs1 = 0;
  int hs2 = 0;

  typedef struct {
    int         len;     // message length in bytes
    int         stall;   // cycles out_ready stays low per block
    bit         extra;   // message closed by a separate k=0 last word
    int         nblk;    // expected number of output blocks
    int         padblk;  // block holding the domain-suffix byte
    int         padpos;  // byte offset of that byte
    logic [7:0] padval;  // its expected value
  } vec_t;

  vec_t tbl[7];

  shake_absorb_padder #(.RATE(1088), .W(64), .DS(8'h1F)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready)
  );

  shake_absorb_padder #(.RATE(576), .W(64), .DS(8'h06)) dut2 (
    .clk(clk), .rst(rst2), .in_data(d2_in_data), .in_valid(d2_in_valid),
    .in_last(d2_in_last), .in_bytes(d2_in_bytes), .in_ready(d2_in_ready),
    .out_data(d2_out_data), .out_valid(d2_out_valid), .out_last(d2_out_last),
    .out_ready(d2_out_ready)
  );

  always #5 clk = ~clk;

  // Output handshake counters.
  always @(posedge clk) begin
    if (out_valid && out_ready) hs1 <= hs1 + 1;
    if (d2_out_valid && d2_out_ready) hs2 <= hs2 + 1;
  end

  // Illegal byte count on a final word.
  always @(negedge clk) begin
    if (in_valid && in_ready && in_last) begin
      assert (in_bytes <= 4'd8) else $error("in_bytes %0d exceeds W/8", in_bytes);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [1087:0] act, input logic [1087:0] exp);
    int idx;
    checks++;
    if (act !== exp) begin
      errors++;
      idx = 0;
      for (int j = 0; j < 136; j++) begin
        if (act[1087-8*j -: 8] !== exp[1087-8*j -: 8]) begin
          idx = j;
          break;
        end
      end
      $display("FAIL %s: first differing byte %0d got %0h expected %0h",
               nm, idx, act[1087-8*idx -: 8], exp[1087-8*idx -: 8]);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out (got no event, expected one)", nm);
  endtask

  function automatic logic [7:0] msg_byte(input int i);
    return 8'(170 + 17 * i);
  endfunction

  // Expected block: message bytes in order; the final block gets DS at the
  // end of the message and 0x80 in its last byte.
  function automatic logic [1087:0] exp_block(input int len, input int blk);
    logic [1087:0] e;
    int fin, g, pos;
    e   = '0;
    fin = len / 136;
    for (int j = 0; j < 136; j++) begin
      g = blk * 136 + j;
      if (g < len) e[1087-8*j -: 8] = msg_byte(g);
    end
    if (blk == fin) begin
      pos = len - blk * 136;
      e[1087-8*pos -: 8] = e[1087-8*pos -: 8] ^ 8'h1F;
      e[7:0] = e[7:0] ^ 8'h80;
    end
    return e;
  endfunction

  // Word w of the message; bytes past k in the last word carry 0xFF garbage.
  function automatic logic [63:0] mk_word(input int w, input bit last, input int k);
    logic [63:0] d;
    for (int b = 0; b < 8; b++) begin
      d[63-8*b -: 8] = (last && b >= k) ? 8'hFF : msg_byte(w * 8 + b);
    end
    return d;
  endfunction

  task automatic send(input logic [63:0] d, input bit last, input int k);
    int t;
    t = 0;
    in_data  = d;
    in_last  = last;
    in_bytes = 4'(k);
    in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) timeout_fail("in_ready wait");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int nwords, k, hs0;
    if (v.extra) begin
      nwords = v.len / 8 + 1;
      k = 0;
    end else if (v.len == 0) begin
      nwords = 1;
      k = 0;
    end else begin
      nwords = (v.len + 7) / 8;
      k = v.len - 8 * (nwords - 1);
    end
    hs0 = hs1;
    fork
      begin : feeder
        for (int w = 0; w < nwords; w++) begin
          send(mk_word(w, w == nwords - 1, k), w == nwords - 1, (w == nwords - 1) ? k : 8);
          if (w == nwords - 1 || (w % 17) == 16)
            chk($sformatf("v%0d out_valid latency w%0d", id, w), 64'(out_valid), 64'd1);
        end
      end
      begin : collector
        for (int b = 0; b < v.nblk; b++) begin
          logic [1087:0] e;
          bit next_pad;
          int t;
          e = exp_block(v.len, b);
          next_pad = (b == 0) && (v.nblk == 2) && (v.len % 136 == 0);
          @(negedge clk);
          t = 0;
          while (!out_valid && t < 300) begin
            @(negedge clk);
            t++;
          end
          if (t >= 300) timeout_fail($sformatf("v%0d out_valid wait b%0d", id, b));
          for (int s = 0; s <= v.stall; s++) begin
            chk_blk($sformatf("v%0d out_data b%0d s%0d", id, b, s), out_data, e);
            chk($sformatf("v%0d out_last b%0d s%0d", id, b, s), 64'(out_last), 64'(b == v.nblk - 1));
            chk($sformatf("v%0d out_valid b%0d s%0d", id, b, s), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d in_ready b%0d s%0d", id, b, s), 64'(in_ready), 64'd0);
            if (s == 0 && b == v.padblk)
              chk($sformatf("v%0d pad byte", id), 64'(out_data[1087-8*v.padpos -: 8]), 64'(v.padval));
            if (s < v.stall) @(negedge clk);
          end
          out_ready = 1'b1;
          @(posedge clk);
          #1;
          out_ready = 1'b0;
          chk($sformatf("v%0d in_ready after hs b%0d", id, b), 64'(in_ready), 64'(!next_pad));
          chk($sformatf("v%0d out_valid after hs b%0d", id, b), 64'(out_valid), 64'(next_pad));
        end
      end
    join
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d no extra block", id), 64'(out_valid), 64'd0);
    chk($sformatf("v%0d handshake count", id), 64'(hs1 - hs0), 64'(v.nblk));
  endtask

  initial begin
    logic [1087:0] e576;
    int hs0;

    //        len  stall extra nblk padblk padpos padval
    tbl[0] = '{0,   0, 1'b0, 1, 0, 0,   8'h1F};
    tbl[1] = '{3,   0, 1'b0, 1, 0, 3,   8'h1F};
    tbl[2] = '{135, 0, 1'b0, 1, 0, 135, 8'h9F};
    tbl[3] = '{136, 0, 1'b0, 2, 1, 0,   8'h1F};
    tbl[4] = '{200, 5, 1'b0, 2, 1, 64,  8'h1F};
    tbl[5] = '{8,   2, 1'b0, 1, 0, 8,   8'h1F};
    tbl[6] = '{16,  0, 1'b1, 1, 0, 16,  8'h1F};

    rst = 1'b1; rst2 = 1'b1;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_bytes = '0; out_ready = 1'b0;
    d2_in_data = '0; d2_in_valid = 1'b0; d2_in_last = 1'b0; d2_in_bytes = '0; d2_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_last", 64'(out_last), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk_blk("reset out_data", out_data, '0);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Reset in the middle of a block, then an empty message.
    hs0 = hs1;
    @(posedge clk); #1;
    for (int w = 0; w < 5; w++) send(mk_word(w, 1'b0, 8), 1'b0, 8);
    chk("midfill out_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midfill reset out_valid", 64'(out_valid), 64'd0);
    chk("midfill reset in_ready", 64'(in_ready), 64'd0);
    chk_blk("midfill reset out_data", out_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midfill in_ready after reset", 64'(in_ready), 64'd1);
    chk("midfill no block", 64'(hs1 - hs0), 64'd0);
    @(posedge clk); #1;
    run_vec(tbl[0], 7);

    // Same on the RATE=576, DS=06 instance.
    e576 = '0;
    e576[575:568] = 8'h06;
    e576[7:0] = 8'h80;
    hs0 = hs2;
    d2_in_valid = 1'b1;
    d2_in_last = 1'b0;
    d2_in_bytes = 4'd8;
    d2_in_data = 64'h0123456789ABCDEF;
    repeat (5) @(posedge clk);
    #1;
    d2_in_valid = 1'b0;
    chk("r576 midfill out_valid", 64'(d2_out_valid), 64'd0);
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0;
    chk("r576 no block", 64'(hs2 - hs0), 64'd0);
    d2_in_valid = 1'b1;
    d2_in_last = 1'b1;
    d2_in_bytes = 4'd0;
    d2_in_data = '1;
    @(posedge clk); #1;
    d2_in_valid = 1'b0;
    d2_in_last = 1'b0;
    chk("r576 out_valid", 64'(d2_out_valid), 64'd1);
    chk("r576 out_last", 64'(d2_out_last), 64'd1);
    chk_blk("r576 out_data", 1088'(d2_out_data), 1088'(e576));
    d2_out_ready = 1'b1;
    @(posedge clk); #1;
    d2_out_ready = 1'b0;
    chk("r576 in_ready after hs", 64'(d2_in_ready), 64'd1);
    chk("r576 handshake count", 64'(hs2 - hs0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
